// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  // Controller FSM state; RUN must encode as 0 so reset lands there.
  typedef enum logic {
    StRun    = 1'b0,
    StMcWait = 1'b1
  } hz_state_e;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // addi x0, x0, 0 -- what a flushed or bubbled pipeline register holds.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/hz_lu_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// register a load in EX is still fetching from memory.
module hz_lu_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_memread,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  // Source-operand match against the load destination; x0 never matches.
  always_comb begin
    rs1_hit = id_use_rs1 && (id_rs1 == id_ex_rd);
    rs2_hit = id_use_rs2 && (id_rs2 == id_ex_rd);
    lu      = id_ex_memread && (id_ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage RV32 core.
// Optional build macro HAZARD_PERF_EN adds perf_lu_cnt/perf_mc_cnt/perf_flush_cnt
// event counters; without it the counters and their ports are absent.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MC_MAX_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_memread,
  input  logic        ex_br_taken,
  input  logic        ex_mc_start,
  input  logic        ex_mc_done,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_mc_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        mc_timeout
);

  localparam int unsigned CntW = $clog2(MC_MAX_CYC + 1);
  localparam logic [CntW-1:0] McLast = CntW'(MC_MAX_CYC - 1);

  hz_state_e       state_q, state_d;
  logic [CntW-1:0] mc_cnt_q, mc_cnt_d;
  logic            timeout_q, timeout_d;

  logic lu;
  logic lu_stall;
  logic flush;
  logic mc_stall;

  hz_lu_detect u_lu_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .id_ex_rd      (id_ex_rd),
    .id_ex_memread (id_ex_memread),
    .lu            (lu)
  );

  // Next-state and Mealy control decode; everything is held low while in reset.
  always_comb begin
    state_d   = state_q;
    mc_cnt_d  = mc_cnt_q;
    timeout_d = 1'b0;
    lu_stall  = 1'b0;
    flush     = 1'b0;
    mc_stall  = 1'b0;

    if (!rst) begin
      unique case (state_q)
        StRun: begin
          // A taken branch squashes the ID instruction, so its hazard is moot.
          if (ex_br_taken) begin
            flush = 1'b1;
          end else if (lu) begin
            lu_stall = 1'b1;
          end
          if (ex_mc_start && !ex_mc_done) begin
            state_d  = StMcWait;
            mc_cnt_d = '0;
          end
        end
        StMcWait: begin
          mc_cnt_d = mc_cnt_q + CntW'(1);
          // In the done cycle the EX result advances, so the pipe runs freely.
          if (ex_mc_done) begin
            state_d = StRun;
          end else begin
            mc_stall = 1'b1;
            if (mc_cnt_q == McLast) begin
              timeout_d = 1'b1;
              state_d   = StRun;
            end
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Pipeline register controls derived from the three hazard causes.
  always_comb begin
    pc_stall      = lu_stall | mc_stall;
    if_id_stall   = lu_stall | mc_stall;
    if_id_flush   = flush;
    id_ex_stall   = mc_stall;
    id_ex_bubble  = lu_stall | flush;
    ex_mem_bubble = mc_stall;
    mc_timeout    = timeout_q & ~rst;
  end

  // FSM state, watchdog counter and registered timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      mc_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mc_cnt_q  <= mc_cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_EN
  // Event counters: one increment per stall/wait/flush cycle, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_cnt    <= '0;
      perf_mc_cnt    <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_lu_cnt    <= perf_lu_cnt + 32'(lu_stall);
      perf_mc_cnt    <= perf_mc_cnt + 32'(mc_stall);
      perf_flush_cnt <= perf_flush_cnt + 32'(flush);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push the expected control
// word per cycle; a negedge monitor pops and compares against the DUT.
module tb_hazard_ctrl;

  localparam int unsigned MaxCyc = 8;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble, mc_timeout}
  localparam logic [6:0] ZZ  = 7'b0000000;
  localparam logic [6:0] LU  = 7'b1100100;
  localparam logic [6:0] MCW = 7'b1101010;
  localparam logic [6:0] FL  = 7'b0010100;
  localparam logic [6:0] TO  = 7'b0000001;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_use_rs1, id_use_rs2, id_ex_memread;
  logic       ex_br_taken, ex_mc_start, ex_mc_done;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic       id_ex_bubble, ex_mem_bubble, mc_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_cnt, perf_mc_cnt, perf_flush_cnt;
`endif

  typedef struct {
    logic [6:0] v;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   t_lu   = 0;
  int   t_mc   = 0;
  int   t_fl   = 0;

  hazard_ctrl #(
    .MC_MAX_CYC (MaxCyc)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .id_ex_rd      (id_ex_rd),
    .id_ex_memread (id_ex_memread),
    .ex_br_taken   (ex_br_taken),
    .ex_mc_start   (ex_mc_start),
    .ex_mc_done    (ex_mc_done),
    .pc_stall      (pc_stall),
    .if_id_stall   (if_id_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_stall   (id_ex_stall),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_bubble (ex_mem_bubble),
`ifdef HAZARD_PERF_EN
    .perf_lu_cnt   (perf_lu_cnt),
    .perf_mc_cnt   (perf_mc_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .mc_timeout    (mc_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are Mealy, so each issued cycle is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t       e;
      logic [6:0] act;
      e   = sb.pop_front();
      act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
             id_ex_bubble, ex_mem_bubble, mc_timeout};
      n_chk++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
      end
    end
  end

  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic st, input logic dn,
                      input logic [6:0] ev, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_ex_rd = rd; id_ex_memread = mr; ex_br_taken = br; ex_mc_start = st; ex_mc_done = dn;
    e.v  = ev;
    e.nm = nm;
    sb.push_back(e);
    if (r) begin
      t_lu = 0; t_mc = 0; t_fl = 0;
    end else begin
      if (ev == LU)  t_lu++;
      if (ev == MCW) t_mc++;
      if (ev[4])     t_fl++;
    end
  endtask

  task automatic idle(input string nm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZZ, nm);
  endtask

  initial begin
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_ex_rd = '0; id_ex_memread = 0; ex_br_taken = 0; ex_mc_start = 0; ex_mc_done = 0;

    // Reset forces outputs low even with a live hazard on the inputs.
    step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, ZZ, "reset_forced_zero");
    step(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, ZZ, "reset_forced_zero_br");

    // Reset in the middle of a multi-cycle wait.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZZ, "mc_start_a");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCW, "mc_wait_a");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZZ, "rst_in_mc_wait");
    idle("run_after_rst");
    idle("no_timeout_after_rst");

    // Load-use on rs1, then the load leaves EX.
    step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, LU, "lu_rs1");
    idle("lu_one_cycle");

    // Non-hazards and the rs2 path.
    step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, ZZ, "lu_rd_zero");
    step(0, 0, 5, 0, 0, 5, 1, 0, 0, 0, ZZ, "lu_rs2_unused");
    step(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, LU, "lu_rs2");
    step(0, 5, 0, 1, 0, 5, 0, 0, 0, 0, ZZ, "no_load");

    // Multi-cycle op: start, three wait cycles, done cycle runs freely.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZZ, "mc_start_b");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCW, "mc_wait_b1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCW, "mc_wait_b2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCW, "mc_wait_b3");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ZZ, "mc_done_run");
    idle("after_done");

    // Start and done together stays in RUN.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ZZ, "start_done_same");
    idle("stay_run");

    // Watchdog: no done for MaxCyc wait cycles; branch/lu ignored while waiting.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZZ, "mc_start_c");
    for (int i = 0; i < int'(MaxCyc); i++) begin
      if (i == 2)      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MCW, "br_ignored_in_wait");
      else if (i == 4) step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, MCW, "lu_ignored_in_wait");
      else if (i == 5) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MCW, "start_ignored_in_wait");
      else             step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCW, "mc_wait_c");
    end
    step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, LU | TO, "timeout_pulse_run");
    idle("timeout_one_cycle");

    // Branch flush beats load-use; branch with MC start still enters the wait.
    step(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, FL, "br_over_lu");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FL, "br_with_start");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MCW, "mc_wait_after_br");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ZZ, "mc_done_after_br");
    idle("tail_1");
    idle("tail_2");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

`ifdef HAZARD_PERF_EN
    // The timeout cycle also carried a load-use stall.
    t_lu++;
    n_chk++;
    if (perf_lu_cnt !== 32'(t_lu)) begin
      n_fail++;
      $display("FAIL perf_lu_cnt: got %0d expected %0d", perf_lu_cnt, t_lu);
    end
    n_chk++;
    if (perf_mc_cnt !== 32'(t_mc)) begin
      n_fail++;
      $display("FAIL perf_mc_cnt: got %0d expected %0d", perf_mc_cnt, t_mc);
    end
    n_chk++;
    if (perf_flush_cnt !== 32'(t_fl)) begin
      n_fail++;
      $display("FAIL perf_flush_cnt: got %0d expected %0d", perf_flush_cnt, t_fl);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
